// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment encoder/capture blocks.
//   - cap_state_t : capture FSM state encoding
//   - SEG_TABLE   : active-high {a,b,c,d,e,f,g} pattern for hex digits 0..F
//   - SEG_BLANK   : all-segments-off pattern (legal blank digit)
//   - is_onehot4  : true when exactly one of four bits is set
//   - onehot_index: bit position of a one-hot 4-bit vector
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_SEL = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_HELD     = 2'd2
    } cap_state_t;

    // Index is the hex value; a_g[6] = a ... a_g[0] = g.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,
        7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F,
        7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational reverse lookup of an active-high segment pattern.
// Ports:
//   pattern [6:0] in  : {a,b,c,d,e,f,g}, 1 = lit
//   value   [3:0] out : hex value of the pattern (0 for blank or illegal)
//   blank         out : pattern has every segment off
//   illegal       out : pattern is neither blank nor a table entry
// -----------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       blank,
    output logic       illegal
);

    logic [15:0] match;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_match
            assign match[gi] = (pattern == SEG_TABLE[gi]);
        end
    endgenerate

    // Table entries are all distinct, so at most one match bit is set.
    always_comb begin
        value = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (match[i]) begin
                value = 4'(i);
            end
        end
    end

    assign blank   = (pattern == SEG_BLANK);
    assign illegal = !blank && (match == 16'd0);

endmodule

// File: rtl/seg7_capture.sv
// -----------------------------------------------------------------------------
// seg7_capture
// Snoops a multiplexed 4-digit seven-segment display bus and reconstructs the
// hex digits being shown. Each digit is sampled once its select and segment
// lines have been stable for SETTLE cycles; a frame is published once all four
// digits have been sampled legally.
// Parameters:
//   SETTLE          stable cycles required before sampling (1..255)
//   POS_ACTIVE_LOW  1: a selected digit drives its pos bit low
//   SEG_ACTIVE_LOW  1: a lit segment / dp drives its line low
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   pos   [3:0]  in   digit select lines, bit k = digit k
//   a_g   [6:0]  in   segment lines, a_g[6] = a ... a_g[0] = g
//   dp           in   decimal point line
//   d0..d3 [3:0] out  hex value of each digit from the last complete frame
//   dp_mask [3:0] out decimal point state per digit, 1 = lit
//   blank_mask[3:0] out 1 = digit had all segments off
//   frame_valid  out  one-cycle pulse when the digit outputs update
//   seg_err      out  one-cycle pulse on an undecodable sampled pattern
// -----------------------------------------------------------------------------
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE         = 4,
    parameter bit POS_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] pos,
    input  logic [6:0] a_g,
    input  logic       dp,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [3:0] dp_mask,
    output logic [3:0] blank_mask,
    output logic       frame_valid,
    output logic       seg_err
);

    // ---------------- input synchronizer: {dp, a_g, pos} ----------------
    logic [11:0] sync1_reg;
    logic [11:0] sync2_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= {dp, a_g, pos};
            sync2_reg <= sync1_reg;
        end
    end

    // ---------------- normalize to active-high ----------------
    logic [3:0] pos_norm;
    logic [6:0] seg_norm;
    logic       dp_norm;

    assign pos_norm = POS_ACTIVE_LOW ? ~sync2_reg[3:0]  : sync2_reg[3:0];
    assign seg_norm = SEG_ACTIVE_LOW ? ~sync2_reg[10:4] : sync2_reg[10:4];
    assign dp_norm  = SEG_ACTIVE_LOW ? ~sync2_reg[11]   : sync2_reg[11];

    // Previous-cycle copies used for the stability check while settling.
    logic [3:0] prev_pos_reg;
    logic [6:0] prev_seg_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_pos_reg <= '0;
            prev_seg_reg <= '0;
        end else begin
            prev_pos_reg <= pos_norm;
            prev_seg_reg <= seg_norm;
        end
    end

    // ---------------- pattern decode ----------------
    logic [3:0] dec_value;
    logic       dec_blank;
    logic       dec_illegal;

    seg7_decode u_decode (
        .pattern (seg_norm),
        .value   (dec_value),
        .blank   (dec_blank),
        .illegal (dec_illegal)
    );

    // ---------------- capture FSM and staging ----------------
    cap_state_t state_reg;
    logic [7:0] cnt_reg;
    logic [3:0] held_pos_reg;
    logic [3:0] seen_reg;
    logic [3:0] stage_val_reg [4];
    logic [3:0] stage_dp_reg;
    logic [3:0] stage_blank_reg;
    logic [3:0] out_val_reg [4];
    logic [3:0] dp_mask_reg;
    logic [3:0] blank_mask_reg;
    logic       frame_valid_reg;
    logic       seg_err_reg;

    logic       inputs_changed;
    logic [8:0] cnt_inc;
    logic       sample_now;
    logic       frame_done;
    logic [3:0] seen_base;
    logic [1:0] sel_idx;

    assign inputs_changed = (pos_norm != prev_pos_reg) || (seg_norm != prev_seg_reg);
    // Counter already holds the stable cycles seen so far; this cycle adds one.
    assign cnt_inc        = {1'b0, cnt_reg} + 9'd1;
    assign sample_now     = (state_reg == ST_SETTLE) && !inputs_changed
                            && (cnt_inc >= 9'(SETTLE));
    assign frame_done     = (seen_reg == 4'hF);
    // A completed frame is consumed this cycle, so seen bits restart from zero.
    assign seen_base      = frame_done ? 4'h0 : seen_reg;
    assign sel_idx        = onehot_index(pos_norm);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_WAIT_SEL;
            cnt_reg         <= '0;
            held_pos_reg    <= '0;
            seen_reg        <= '0;
            stage_dp_reg    <= '0;
            stage_blank_reg <= '0;
            dp_mask_reg     <= '0;
            blank_mask_reg  <= '0;
            frame_valid_reg <= 1'b0;
            seg_err_reg     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                stage_val_reg[i] <= '0;
                out_val_reg[i]   <= '0;
            end
        end else begin
            frame_valid_reg <= 1'b0;
            seg_err_reg     <= 1'b0;

            case (state_reg)
                ST_WAIT_SEL: begin
                    if (is_onehot4(pos_norm)) begin
                        cnt_reg   <= 8'd1;
                        state_reg <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (inputs_changed) begin
                        state_reg <= ST_WAIT_SEL;
                    end else if (sample_now) begin
                        held_pos_reg <= pos_norm;
                        state_reg    <= ST_HELD;
                    end else begin
                        cnt_reg <= cnt_inc[7:0];
                    end
                end
                ST_HELD: begin
                    // Only a select change ends the hold; segment changes
                    // on the same digit are ignored.
                    if (pos_norm != held_pos_reg) begin
                        state_reg <= ST_WAIT_SEL;
                    end
                end
                default: state_reg <= ST_WAIT_SEL;
            endcase

            if (frame_done) begin
                for (int i = 0; i < 4; i++) begin
                    out_val_reg[i] <= stage_val_reg[i];
                end
                dp_mask_reg     <= stage_dp_reg;
                blank_mask_reg  <= stage_blank_reg;
                frame_valid_reg <= 1'b1;
            end

            if (sample_now && dec_illegal) begin
                seg_err_reg <= 1'b1;
                seen_reg    <= 4'h0;
            end else if (sample_now) begin
                stage_val_reg[sel_idx]   <= dec_value;
                stage_dp_reg[sel_idx]    <= dp_norm;
                stage_blank_reg[sel_idx] <= dec_blank;
                seen_reg                 <= seen_base | pos_norm;
            end else begin
                seen_reg <= seen_base;
            end
        end
    end

    assign d0          = out_val_reg[0];
    assign d1          = out_val_reg[1];
    assign d2          = out_val_reg[2];
    assign d3          = out_val_reg[3];
    assign dp_mask     = dp_mask_reg;
    assign blank_mask  = blank_mask_reg;
    assign frame_valid = frame_valid_reg;
    assign seg_err     = seg_err_reg;

endmodule

// File: tb/tb_seg7_capture.sv
// -----------------------------------------------------------------------------
// tb_seg7_capture
// Directed scenarios for seg7_capture with default parameters (SETTLE=4,
// active-low select and segments). Pins are driven as a display driver would.
// -----------------------------------------------------------------------------
module tb_seg7_capture;

    logic       clk;
    logic       reset;
    logic [3:0] pos;
    logic [6:0] a_g;
    logic       dp;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] dp_mask;
    logic [3:0] blank_mask;
    logic       frame_valid;
    logic       seg_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int fv_count     = 0;
    int err_count    = 0;

    seg7_capture #(
        .SETTLE         (4),
        .POS_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pos         (pos),
        .a_g         (a_g),
        .dp          (dp),
        .d0          (d0),
        .d1          (d1),
        .d2          (d2),
        .d3          (d3),
        .dp_mask     (dp_mask),
        .blank_mask  (blank_mask),
        .frame_valid (frame_valid),
        .seg_err     (seg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (frame_valid === 1'b1) fv_count++;
            if (seg_err === 1'b1) err_count++;
        end
    end

    // Active-high {a..g} patterns, written out by hand.
    function automatic logic [6:0] hex_pat(input int v);
        logic [6:0] p;
        case (v)
            0: p = 7'h7E;  1: p = 7'h30;  2: p = 7'h6D;  3: p = 7'h79;
            4: p = 7'h33;  5: p = 7'h5B;  6: p = 7'h5F;  7: p = 7'h70;
            8: p = 7'h7F;  9: p = 7'h7B;  10: p = 7'h77; 11: p = 7'h1F;
            12: p = 7'h4E; 13: p = 7'h3D; 14: p = 7'h4F; default: p = 7'h47;
        endcase
        return p;
    endfunction

    // Drive digit k with active-high pattern pat, as active-low pins.
    task automatic drive_digit(input int k, input logic [6:0] pat, input logic dp_on,
                               input int cycles);
        logic [3:0] sel;
        sel = 4'b0001 << k;
        pos = ~sel;
        a_g = ~pat;
        dp  = ~dp_on;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic drive_raw(input logic [3:0] pos_pins, input logic [6:0] seg_pins,
                             input int cycles);
        pos = pos_pins;
        a_g = seg_pins;
        dp  = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        drive_raw(4'hF, 7'h7F, cycles);
    endtask

    task automatic scan4(input int v0, input int v1, input int v2, input int v3,
                         input logic [3:0] dps);
        drive_digit(0, hex_pat(v0), dps[0], 20);
        drive_digit(1, hex_pat(v1), dps[1], 20);
        drive_digit(2, hex_pat(v2), dps[2], 20);
        drive_digit(3, hex_pat(v3), dps[3], 20);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        pos = 4'hF; a_g = 7'h7F; dp = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_digits: got %h expected 0000", {d3, d2, d1, d0});
        end
        tests_run++;
        if ({dp_mask, blank_mask} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_masks: got %h expected 00", {dp_mask, blank_mask});
        end
        tests_run++;
        if ({frame_valid, seg_err} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_pulses: got %b expected 00", {frame_valid, seg_err});
        end
        reset = 1'b1;
        idle(5);
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_scan;
        int fv0, er0;
        fv0 = fv_count; er0 = err_count;
        scan4(1, 2, 3, 4, 4'b0100);
        scan4(1, 2, 3, 4, 4'b0100);
        idle(12);
        tests_run++;
        if (fv_count - fv0 !== 2) begin
            tests_failed++;
            $display("FAIL scan_frames: got %0d expected 2", fv_count - fv0);
        end
        tests_run++;
        if (err_count - er0 !== 0) begin
            tests_failed++;
            $display("FAIL scan_err: got %0d expected 0", err_count - er0);
        end
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h4321) begin
            tests_failed++;
            $display("FAIL scan_digits: got %h expected 4321", {d3, d2, d1, d0});
        end
        tests_run++;
        if (dp_mask !== 4'b0100) begin
            tests_failed++;
            $display("FAIL scan_dp: got %b expected 0100", dp_mask);
        end
        tests_run++;
        if (blank_mask !== 4'b0000) begin
            tests_failed++;
            $display("FAIL scan_blank: got %b expected 0000", blank_mask);
        end
        idle(20);
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h4321) begin
            tests_failed++;
            $display("FAIL scan_hold: got %h expected 4321", {d3, d2, d1, d0});
        end
        $display("[TB] scan 1,2,3,4: frames=%0d digits=%h", fv_count - fv0, {d3, d2, d1, d0});
    endtask

    task automatic test_glitch;
        int fv0, er0;
        fv0 = fv_count; er0 = err_count;
        drive_digit(0, 7'h01, 1'b0, 2);          // 2-cycle illegal glitch
        drive_digit(0, hex_pat(7), 1'b0, 18);
        drive_digit(1, hex_pat(0), 1'b0, 20);
        drive_digit(2, hex_pat(10), 1'b0, 20);
        drive_digit(3, hex_pat(15), 1'b0, 20);
        idle(12);
        tests_run++;
        if (fv_count - fv0 !== 1) begin
            tests_failed++;
            $display("FAIL glitch_frames: got %0d expected 1", fv_count - fv0);
        end
        tests_run++;
        if (err_count - er0 !== 0) begin
            tests_failed++;
            $display("FAIL glitch_err: got %0d expected 0", err_count - er0);
        end
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'hFA07) begin
            tests_failed++;
            $display("FAIL glitch_digits: got %h expected fa07", {d3, d2, d1, d0});
        end
        $display("[TB] glitch: frames=%0d digits=%h", fv_count - fv0, {d3, d2, d1, d0});
    endtask

    task automatic test_illegal;
        int fv0, er0;
        fv0 = fv_count; er0 = err_count;
        drive_digit(0, hex_pat(1), 1'b0, 20);
        drive_digit(1, 7'h01, 1'b0, 20);
        drive_digit(2, hex_pat(3), 1'b0, 20);
        drive_digit(3, hex_pat(4), 1'b0, 20);
        idle(12);
        tests_run++;
        if (fv_count - fv0 !== 0) begin
            tests_failed++;
            $display("FAIL illegal_no_frame: got %0d expected 0", fv_count - fv0);
        end
        tests_run++;
        if (err_count - er0 !== 1) begin
            tests_failed++;
            $display("FAIL illegal_err: got %0d expected 1", err_count - er0);
        end
        // Digits 2,3 are already staged; two more legal samples finish the frame.
        drive_digit(0, hex_pat(5), 1'b0, 20);
        drive_digit(1, hex_pat(6), 1'b0, 20);
        idle(12);
        tests_run++;
        if (fv_count - fv0 !== 1) begin
            tests_failed++;
            $display("FAIL illegal_frames: got %0d expected 1", fv_count - fv0);
        end
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h4365) begin
            tests_failed++;
            $display("FAIL illegal_digits: got %h expected 4365", {d3, d2, d1, d0});
        end
        tests_run++;
        if (err_count - er0 !== 1) begin
            tests_failed++;
            $display("FAIL illegal_err_total: got %0d expected 1", err_count - er0);
        end
        $display("[TB] illegal: errs=%0d frames=%0d digits=%h", err_count - er0,
                 fv_count - fv0, {d3, d2, d1, d0});
    endtask

    task automatic test_no_select;
        int fv0, er0;
        fv0 = fv_count; er0 = err_count;
        drive_raw(4'b1111, ~hex_pat(8), 100);    // normalized 0000
        drive_raw(4'b1100, ~hex_pat(8), 100);    // normalized 0011
        idle(12);
        tests_run++;
        if (fv_count - fv0 !== 0) begin
            tests_failed++;
            $display("FAIL nosel_frames: got %0d expected 0", fv_count - fv0);
        end
        tests_run++;
        if (err_count - er0 !== 0) begin
            tests_failed++;
            $display("FAIL nosel_err: got %0d expected 0", err_count - er0);
        end
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h4365) begin
            tests_failed++;
            $display("FAIL nosel_hold: got %h expected 4365", {d3, d2, d1, d0});
        end
        $display("[TB] no select: frames=%0d errs=%0d", fv_count - fv0, err_count - er0);
    endtask

    task automatic test_reset_midframe;
        int fv0, er0;
        drive_digit(0, hex_pat(9), 1'b0, 20);
        drive_digit(1, hex_pat(8), 1'b0, 20);
        drive_digit(2, hex_pat(7), 1'b0, 20);
        drive_digit(3, hex_pat(6), 1'b0, 3);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL midrst_digits: got %h expected 0000", {d3, d2, d1, d0});
        end
        tests_run++;
        if ({dp_mask, blank_mask} !== 8'h00) begin
            tests_failed++;
            $display("FAIL midrst_masks: got %h expected 00", {dp_mask, blank_mask});
        end
        tests_run++;
        if ({frame_valid, seg_err} !== 2'b00) begin
            tests_failed++;
            $display("FAIL midrst_pulses: got %b expected 00", {frame_valid, seg_err});
        end
        idle(2);
        reset = 1'b1;
        idle(5);
        fv0 = fv_count; er0 = err_count;
        scan4(9, 8, 7, 6, 4'b0000);
        idle(12);
        tests_run++;
        if (fv_count - fv0 !== 1) begin
            tests_failed++;
            $display("FAIL midrst_frames: got %0d expected 1", fv_count - fv0);
        end
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h6789) begin
            tests_failed++;
            $display("FAIL midrst_digits_after: got %h expected 6789", {d3, d2, d1, d0});
        end
        tests_run++;
        if (err_count - er0 !== 0) begin
            tests_failed++;
            $display("FAIL midrst_err: got %0d expected 0", err_count - er0);
        end
        $display("[TB] reset mid-frame: frames=%0d digits=%h", fv_count - fv0, {d3, d2, d1, d0});
    endtask

    task automatic test_blank;
        int fv0;
        fv0 = fv_count;
        drive_digit(0, 7'h00, 1'b0, 20);
        drive_digit(1, 7'h00, 1'b0, 20);
        drive_digit(2, 7'h00, 1'b0, 20);
        drive_digit(3, 7'h00, 1'b0, 20);
        idle(12);
        tests_run++;
        if (fv_count - fv0 !== 1) begin
            tests_failed++;
            $display("FAIL blank_frames: got %0d expected 1", fv_count - fv0);
        end
        tests_run++;
        if (blank_mask !== 4'b1111) begin
            tests_failed++;
            $display("FAIL blank_mask: got %b expected 1111", blank_mask);
        end
        tests_run++;
        if ({d3, d2, d1, d0} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL blank_digits: got %h expected 0000", {d3, d2, d1, d0});
        end
        tests_run++;
        if (dp_mask !== 4'b0000) begin
            tests_failed++;
            $display("FAIL blank_dp: got %b expected 0000", dp_mask);
        end
        $display("[TB] blank: blank_mask=%b digits=%h", blank_mask, {d3, d2, d1, d0});
    endtask

    initial begin
        reset = 1'b0;
        pos   = 4'hF;
        a_g   = 7'h7F;
        dp    = 1'b1;
        @(negedge clk);
        test_reset();
        test_scan();
        test_glitch();
        test_illegal();
        test_no_select();
        test_reset_midframe();
        test_blank();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
